ffe_adapt_engine: RTL and testbench

- Next-generation FFE coefficient adaptation engine. Owns the FFE coefficient bank and updates it from FIR-output/regressor snapshots.
- Supports CMA (blind) and decision-directed LMS (DD), with automatic CMA-to-DD switchover after a programmable update count.
- Time-multiplexes N_PAR tap updaters across FFE_LEN taps with a valid/ready handshake.
- Sits between the FFE datapath, which supplies the snapshots, and the FFE tap registers, which consume o_coeff_flat.

---
 rtl/ffe_adapt_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_ffe_adapt_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ffe_adapt_engine.sv
// ffe_adapt_engine
//   FFE coefficient adaptation engine. Owns the coefficient bank and updates it
//   from FIR-output/regressor snapshots, using CMA (blind) or decision-directed
//   LMS. It switches from CMA to DD automatically after a programmable number of
//   updates. N_PAR tap updaters are time-multiplexed over the FFE_LEN taps.
//
// Ports
//   i_clock, i_reset            clock, asynchronous active-low reset
//   i_valid / o_ready           snapshot handshake
//   i_fir_out                   FIR output y, Q(NBF_I)
//   i_xk_flat                   regressor x[k], tap k at [k*NB_I +: NB_I]
//   i_cma_r, i_dd_level         CMA radius R and DD decision level, Q(NBF)
//   i_mu_cma, i_mu_dd           unsigned step sizes, Q(NBF_MU)
//   i_auto_switch, i_switch_cnt automatic CMA->DD switch control
//   i_force_dd                  force DD mode (sampled at acceptance/commit)
//   i_freeze                    accept snapshots without updating
//   o_coeff_flat                coefficient bank, tap k at [k*NB +: NB]
//   o_coeff_valid               one-cycle pulse when a full bank update commits
//   o_mode                      0 = CMA, 1 = DD (sticky until reset)
//   o_update_cnt                committed bank updates, saturating
module ffe_adapt_engine #(
  parameter int NB_I          = 18,
  parameter int NBF_I         = 15,
  parameter int FFE_LEN       = 21,
  parameter int NB            = 8,
  parameter int NBF           = 7,
  parameter int NB_MU         = 16,
  parameter int NBF_MU        = 15,
  parameter int N_PAR         = 4,
  parameter int CENTER_IDX    = 10,
  parameter int CENTER_INIT   = 64,
  parameter int STARTUP_DELAY = 63
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic signed [NB_I-1:0]    i_fir_out,
  input  logic [NB_I*FFE_LEN-1:0]   i_xk_flat,
  input  logic signed [NB-1:0]      i_cma_r,
  input  logic signed [NB-1:0]      i_dd_level,
  input  logic [NB_MU-1:0]          i_mu_cma,
  input  logic [NB_MU-1:0]          i_mu_dd,
  input  logic                      i_auto_switch,
  input  logic [15:0]               i_switch_cnt,
  input  logic                      i_force_dd,
  input  logic                      i_freeze,
  output logic [NB*FFE_LEN-1:0]     o_coeff_flat,
  output logic                      o_coeff_valid,
  output logic                      o_mode,
  output logic [15:0]               o_update_cnt
);

  localparam int P    = (FFE_LEN + N_PAR - 1) / N_PAR;
  localparam int NPAD = P * N_PAR;
  localparam int GCW  = (P > 1) ? $clog2(P) : 1;
  localparam int IW   = (NPAD > 1) ? $clog2(NPAD) : 1;
  localparam int SCW  = $clog2(STARTUP_DELAY + 2);

  // Full-precision widths: CMA error (frac 2*NBF_I), gradient (frac 4*NBF_I),
  // mu*gradient (frac 4*NBF_I+NBF_MU), and the pre-saturation weight.
  localparam int EWC = 2*NB_I + 2;
  localparam int EWD = NB_I + NB + 2;
  localparam int GW  = EWC + 2*NB_I;
  localparam int PW  = GW + NB_MU + 1;
  localparam int DW  = PW + 1;
  localparam int SH  = 4*NBF_I + NBF_MU - NBF;

  localparam logic signed [PW-1:0] HALF    = PW'(1) <<< (SH - 1);
  localparam logic signed [DW-1:0] WMAX    = DW'((1 << (NB-1)) - 1);
  localparam logic signed [DW-1:0] WMIN    = DW'(-(1 << (NB-1)));
  localparam logic signed [NB-1:0] WMAX_NB = NB'((1 << (NB-1)) - 1);
  localparam logic signed [NB-1:0] WMIN_NB = NB'(-(1 << (NB-1)));

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_COMMIT} state_t;

  state_t                 state, state_nx;
  logic [GCW-1:0]         grp;
  logic [SCW-1:0]         start_cnt;
  logic                   start_done;
  logic                   accept;

  logic signed [NB_I-1:0] y_r;
  logic signed [NB_I-1:0] x_r [FFE_LEN];
  logic signed [NB-1:0]   r_r, lvl_r;
  logic [NB_MU-1:0]       mu_r;
  logic                   dd_r;
  logic                   dd_sel;

  logic signed [NB-1:0]   bank   [FFE_LEN];
  logic signed [NB-1:0]   shadow [FFE_LEN];

  logic signed [EWC-1:0]  ysq, r_al, e_cma;
  logic signed [GW-1:0]   ey;
  logic signed [EWD-1:0]  d_al, e_dd;
  logic signed [NB_MU:0]  mu_s;

  logic signed [NB-1:0]   bank_pad [NPAD];
  logic signed [NB_I-1:0] x_pad    [NPAD];
  logic [IW-1:0]          lane_idx [N_PAR];
  logic signed [NB-1:0]   lane_w   [N_PAR];

  logic [15:0]            cnt_inc;

  // Pass-wide error terms, computed from the frozen snapshot registers.
  always_comb begin
    ysq   = EWC'(y_r) * EWC'(y_r);
    r_al  = EWC'(r_r) <<< (2*NBF_I - NBF);
    e_cma = ysq - r_al;
    ey    = GW'(e_cma) * GW'(y_r);
    d_al  = EWD'(lvl_r) <<< (NBF_I - NBF);
    e_dd  = !y_r[NB_I-1] ? (EWD'(y_r) - d_al) : (EWD'(y_r) + d_al);
    mu_s  = $signed({1'b0, mu_r});
  end

  // One tap update: w - round_half_up(mu*g), saturated to NB bits.
  // The DD gradient (frac 2*NBF_I) is shifted up to share the CMA format.
  function automatic logic signed [NB-1:0] tap_next(
    input logic signed [NB-1:0]   w,
    input logic signed [NB_I-1:0] x
  );
    logic signed [GW-1:0] g;
    logic signed [PW-1:0] prod, delta;
    logic signed [DW-1:0] wn;
    if (dd_r) g = (GW'(e_dd) * GW'(x)) <<< (2*NBF_I);
    else      g = ey * GW'(x);
    prod  = PW'(g) * PW'(mu_s);
    delta = (prod + HALF) >>> SH;
    wn    = DW'(w) - DW'(delta);
    if (wn > WMAX)      return WMAX_NB;
    else if (wn < WMIN) return WMIN_NB;
    else                return wn[NB-1:0];
  endfunction

  // Lane datapath; the bank/regressor are zero-padded to a whole number of
  // groups so the last, partial group needs no special indexing.
  always_comb begin
    for (int unsigned t = 0; t < NPAD; t++) begin
      bank_pad[t] = '0;
      x_pad[t]    = '0;
    end
    for (int unsigned t = 0; t < FFE_LEN; t++) begin
      bank_pad[t] = bank[t];
      x_pad[t]    = x_r[t];
    end
    for (int unsigned j = 0; j < N_PAR; j++) begin
      lane_idx[j] = IW'(32'(grp) * N_PAR + j);
      lane_w[j]   = tap_next(bank_pad[lane_idx[j]], x_pad[lane_idx[j]]);
    end
  end

  assign start_done = (start_cnt >= SCW'(STARTUP_DELAY));
  assign accept     = i_valid && o_ready;
  assign dd_sel     = o_mode || i_force_dd;
  assign cnt_inc    = (o_update_cnt == '1) ? o_update_cnt : o_update_cnt + 16'd1;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid && start_done && !i_freeze) state_nx = S_UPDATE;
      end
      S_UPDATE: if (grp == GCW'(P - 1)) state_nx = S_COMMIT;
      S_COMMIT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      grp           <= '0;
      start_cnt     <= '0;
      y_r           <= '0;
      r_r           <= '0;
      lvl_r         <= '0;
      mu_r          <= '0;
      dd_r          <= 1'b0;
      o_coeff_valid <= 1'b0;
      o_mode        <= 1'b0;
      o_update_cnt  <= '0;
      for (int unsigned t = 0; t < FFE_LEN; t++) begin
        x_r[t]    <= '0;
        shadow[t] <= '0;
        bank[t]   <= (t == CENTER_IDX) ? NB'(CENTER_INIT) : '0;
      end
    end else begin
      o_coeff_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            y_r   <= i_fir_out;
            r_r   <= i_cma_r;
            lvl_r <= i_dd_level;
            dd_r  <= dd_sel;
            mu_r  <= dd_sel ? i_mu_dd : i_mu_cma;
            grp   <= '0;
            for (int unsigned t = 0; t < FFE_LEN; t++)
              x_r[t] <= i_xk_flat[t*NB_I +: NB_I];
            if (!start_done) start_cnt <= start_cnt + SCW'(1);
          end
        end
        S_UPDATE: begin
          grp <= grp + GCW'(1);
          for (int unsigned t = 0; t < FFE_LEN; t++)
            for (int unsigned j = 0; j < N_PAR; j++)
              if (lane_idx[j] == IW'(t)) shadow[t] <= lane_w[j];
        end
        S_COMMIT: begin
          for (int unsigned t = 0; t < FFE_LEN; t++) bank[t] <= shadow[t];
          o_coeff_valid <= 1'b1;
          o_update_cnt  <= cnt_inc;
          if (i_force_dd || (i_auto_switch && (cnt_inc >= i_switch_cnt)))
            o_mode <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_coeff_flat = '0;
    for (int unsigned t = 0; t < FFE_LEN; t++) o_coeff_flat[t*NB +: NB] = bank[t];
  end

endmodule

// File: tb/tb_ffe_adapt_engine.sv
// Directed bench for ffe_adapt_engine (STARTUP_DELAY=3, other parameters default).
module tb_ffe_adapt_engine;
  localparam int NB_I    = 18;
  localparam int FFE_LEN = 21;
  localparam int NB      = 8;
  localparam int NB_MU   = 16;
  localparam int FW      = NB*FFE_LEN;

  logic                    i_clock, i_reset, i_valid, o_ready;
  logic signed [NB_I-1:0]  i_fir_out;
  logic [NB_I*FFE_LEN-1:0] i_xk_flat;
  logic signed [NB-1:0]    i_cma_r, i_dd_level;
  logic [NB_MU-1:0]        i_mu_cma, i_mu_dd;
  logic                    i_auto_switch, i_force_dd, i_freeze;
  logic [15:0]             i_switch_cnt;
  logic [FW-1:0]           o_coeff_flat;
  logic                    o_coeff_valid, o_mode;
  logic [15:0]             o_update_cnt;

  ffe_adapt_engine #(.STARTUP_DELAY(3)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_fir_out(i_fir_out), .i_xk_flat(i_xk_flat), .i_cma_r(i_cma_r),
    .i_dd_level(i_dd_level), .i_mu_cma(i_mu_cma), .i_mu_dd(i_mu_dd),
    .i_auto_switch(i_auto_switch), .i_switch_cnt(i_switch_cnt),
    .i_force_dd(i_force_dd), .i_freeze(i_freeze), .o_coeff_flat(o_coeff_flat),
    .o_coeff_valid(o_coeff_valid), .o_mode(o_mode), .o_update_cnt(o_update_cnt)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int errors = 0;
  int checks = 0;
  logic signed [NB-1:0]   exp_w [FFE_LEN];
  logic signed [NB_I-1:0] xv    [FFE_LEN];

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [FW-1:0] exp_flat();
    logic [FW-1:0] r;
    r = '0;
    for (int t = 0; t < FFE_LEN; t++) r[t*NB +: NB] = exp_w[t];
    return r;
  endfunction

  task automatic init_exp();
    for (int t = 0; t < FFE_LEN; t++) exp_w[t] = '0;
    exp_w[10] = 8'sd64;
  endtask

  task automatic clear_x();
    for (int t = 0; t < FFE_LEN; t++) xv[t] = '0;
  endtask

  task automatic pack_x();
    for (int t = 0; t < FFE_LEN; t++) i_xk_flat[t*NB_I +: NB_I] = xv[t];
  endtask

  // Called at a negedge with the engine idle; returns at the negedge where
  // o_coeff_valid is seen (or after the cycle budget runs out).
  task automatic run_pass(input string tag, input logic signed [NB_I-1:0] y,
                          input logic signed [NB-1:0] r,
                          input logic [NB_MU-1:0] mu_c, input logic [NB_MU-1:0] mu_d);
    int n;
    i_fir_out = y;
    i_cma_r   = r;
    i_mu_cma  = mu_c;
    i_mu_dd   = mu_d;
    pack_x();
    i_valid = 1'b1;
    check({tag, "_ready"}, o_ready, 1'b1);
    @(posedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
    n = 0;
    while (!o_coeff_valid && n < 20) begin
      @(negedge i_clock);
      n++;
    end
    check({tag, "_latency"}, n, 7);
    check({tag, "_bank"}, o_coeff_flat, exp_flat());
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_fir_out = '0; i_xk_flat = '0;
    i_cma_r = 8'sd64; i_dd_level = 8'sd64; i_mu_cma = 16'd32768; i_mu_dd = 16'd32768;
    i_auto_switch = 1'b0; i_switch_cnt = 16'd0; i_force_dd = 1'b0; i_freeze = 1'b0;
    init_exp();
    clear_x();
    pack_x();

    // Reset state
    repeat (2) @(negedge i_clock);
    check("rst_bank", o_coeff_flat, exp_flat());
    check("rst_ready", o_ready, 1'b1);
    check("rst_mode", o_mode, 1'b0);
    check("rst_cnt", o_update_cnt, 16'd0);
    check("rst_valid", o_coeff_valid, 1'b0);
    i_reset = 1'b1;
    repeat (3) @(negedge i_clock);
    check("idle_bank", o_coeff_flat, exp_flat());
    check("idle_valid", o_coeff_valid, 1'b0);
    check("idle_cnt", o_update_cnt, 16'd0);

    // Startup: 3 discarded snapshots, 4th runs a full pass (x=0, bank unchanged)
    i_fir_out = 18'sd16384;
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clock);
      @(negedge i_clock);
      check("startup_valid", o_coeff_valid, 1'b0);
      check("startup_ready", o_ready, 1'b1);
    end
    @(posedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("pass_ready", o_ready, (k == 7));
      check("pass_valid", o_coeff_valid, (k == 7));
      if (k < 7) @(negedge i_clock);
    end
    check("startup_cnt", o_update_cnt, 16'd1);
    check("startup_bank", o_coeff_flat, exp_flat());

    // CMA step: e=-0.25, g=-0.0625, tap10 64 -> 72
    xv[10] = 18'sd16384;
    exp_w[10] = 8'sd72;
    run_pass("cma_step", 18'sd16384, 8'sd64, 16'd32768, 16'd32768);
    check("cma_cnt", o_update_cnt, 16'd2);

    // Saturation high: +56 LSB clips at 127, then +5 LSB stays at 127
    xv[10] = 18'sd114688;
    exp_w[10] = 8'sd127;
    run_pass("sat_hi_a", 18'sd16384, 8'sd64, 16'd32768, 16'd32768);
    xv[10] = 18'sd10240;
    run_pass("sat_hi_b", 18'sd16384, 8'sd64, 16'd32768, 16'd32768);
    // Saturation low: -1024 LSB clips at -128, then -5 LSB stays at -128
    xv[10] = 18'sd32768;
    exp_w[10] = -8'sd128;
    run_pass("sat_lo_a", 18'sd65536, 8'sd0, 16'd32768, 16'd32768);
    xv[10] = 18'sd10240;
    run_pass("sat_lo_b", 18'sd16384, 8'sd0, 16'd32768, 16'd32768);
    check("sat_cnt", o_update_cnt, 16'd6);
    check("sat_mode", o_mode, 1'b0);

    // Auto switch after 2 commits
    i_reset = 1'b0;
    @(negedge i_clock);
    init_exp();
    clear_x();
    check("rst2_bank", o_coeff_flat, exp_flat());
    check("rst2_cnt", o_update_cnt, 16'd0);
    i_reset = 1'b1;
    i_auto_switch = 1'b1;
    i_switch_cnt = 16'd2;
    pack_x();
    @(negedge i_clock);
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clock);
      @(negedge i_clock);
      check("startup2_valid", o_coeff_valid, 1'b0);
    end
    i_valid = 1'b0;
    run_pass("auto_p1", 18'sd16384, 8'sd64, 16'd32768, 16'd32768);
    check("auto_p1_mode", o_mode, 1'b0);
    check("auto_p1_cnt", o_update_cnt, 16'd1);
    run_pass("auto_p2", 18'sd16384, 8'sd64, 16'd32768, 16'd32768);
    check("auto_p2_mode", o_mode, 1'b1);
    check("auto_p2_cnt", o_update_cnt, 16'd2);
    // DD, y=0.3 (9830): e=-6554 LSB(Q15), delta=-12.8 -> -13, tap10 64 -> 77.
    // mu_cma=0 so a CMA-mode step size would leave the bank untouched.
    xv[10] = 18'sd16384;
    exp_w[10] = 8'sd77;
    run_pass("dd_pos", 18'sd9830, 8'sd64, 16'd0, 16'd32768);
    // DD, y=-0.3: e=+6554; taps 0, 10, 20 in first, middle and partial last groups
    xv[0] = 18'sd16384;
    xv[20] = -18'sd16384;
    exp_w[0] = -8'sd13;
    exp_w[10] = 8'sd64;
    exp_w[20] = 8'sd13;
    run_pass("dd_neg", -18'sd9830, 8'sd64, 16'd0, 16'd32768);
    check("dd_mode", o_mode, 1'b1);
    check("dd_cnt", o_update_cnt, 16'd4);

    // Freeze: 5 accepted snapshots, no update
    i_freeze = 1'b1;
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clock);
      @(negedge i_clock);
      check("frz_ready", o_ready, 1'b1);
      check("frz_valid", o_coeff_valid, 1'b0);
    end
    i_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clock);
      check("frz_valid_after", o_coeff_valid, 1'b0);
    end
    check("frz_bank", o_coeff_flat, exp_flat());
    check("frz_cnt", o_update_cnt, 16'd4);
    i_freeze = 1'b0;

    // Reset during the second UPDATE cycle
    i_valid = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
    check("midrst_busy", o_ready, 1'b0);
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    init_exp();
    check("midrst_bank", o_coeff_flat, exp_flat());
    check("midrst_ready", o_ready, 1'b1);
    check("midrst_mode", o_mode, 1'b0);
    check("midrst_cnt", o_update_cnt, 16'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clock);
      check("post_rst_valid", o_coeff_valid, 1'b0);
    end
    check("post_rst_bank", o_coeff_flat, exp_flat());
    check("post_rst_ready", o_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
